// File: rtl/rise_sched_pkg.sv
// Shared types and helpers for the rise-to-response scheduler.
package rise_sched_pkg;

    localparam int RS_NREQ    = 4;
    localparam int RS_LATENCY = 10;

    function automatic int rs_idw(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

    localparam int RS_IDW = rs_idw(RS_NREQ);

    typedef struct packed {
        logic              vld;
        logic [RS_IDW-1:0] id;
    } rs_pipe_t;

endpackage

// File: rtl/rise_resp_sched_arb.sv
// Combinational round-robin picker: first set bit of cand at or above ptr, wrapping.
module rr_arb_onehot
    import rise_sched_pkg::*;
#(
    parameter int N  = RS_NREQ,
    parameter int IW = rs_idw(N)
) (
    input  logic [N-1:0]  cand,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_idx,
    output logic          any
);

    logic found;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && cand[(int'(ptr) + k) % N]) begin
                found                      = 1'b1;
                pick[(int'(ptr) + k) % N]  = 1'b1;
                pick_idx                   = IW'((int'(ptr) + k) % N);
            end
        end
        any = |cand;
    end

endmodule

// File: rtl/rise_resp_sched.sv
// Rising-edge request scheduler with fixed-latency shared response channel.
// Define RISE_SCHED_SVA_EN to compile in the embedded protocol assertions.
module rise_resp_sched
    import rise_sched_pkg::*;
#(
    parameter int NREQ    = RS_NREQ,
    parameter int LATENCY = RS_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     flush,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          pend,
    output logic                     resp_vld,
    output logic [rs_idw(NREQ)-1:0]  resp_id,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int IDW    = rs_idw(NREQ);
    localparam int STAGES = LATENCY - 1;

    logic [NREQ-1:0] req_d,  req_q;
    logic [NREQ-1:0] pend_d, pend_q;
    logic [NREQ-1:0] gnt_d,  gnt_q;
    logic [IDW-1:0]  gid_d,  gid_q;
    logic [IDW-1:0]  ptr_d,  ptr_q;
    logic            ovf_d,  ovf_q;
    rs_pipe_t        pipe_d [STAGES];
    rs_pipe_t        pipe_q [STAGES];

    logic [NREQ-1:0] rise, cand, pick;
    logic [IDW-1:0]  pick_idx;
    logic            any, do_grant;

    rr_arb_onehot #(.N(NREQ), .IW(IDW)) u_arb (
        .cand     (cand),
        .ptr      (ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (any)
    );

    // NOTE: combinational next-state uses blocking '=' with a default for every
    // target first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        req_d    = req;
        rise     = req & ~req_q;
        cand     = pend_q | rise;
        do_grant = en & ~flush & any;

        gnt_d  = do_grant ? pick : '0;
        gid_d  = do_grant ? pick_idx : '0;
        // A rise on an already-pending line merges into the existing entry (dropped).
        pend_d = flush ? '0 : (cand & ~gnt_d);

        ptr_d = ptr_q;
        if (do_grant) begin
            ptr_d = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
        end

        ovf_d = ovf_q;
        if (|(rise & pend_q)) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        pipe_d[0] = '{vld: |gnt_q, id: RS_IDW'(gid_q)};
        for (int i = 1; i < STAGES; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // NOTE: the response pipeline is reset like any other state so that a reset
    // mid-operation discards every in-flight response.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q  <= '0;
            pend_q <= '0;
            gnt_q  <= '0;
            gid_q  <= '0;
            ptr_q  <= '0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < STAGES; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            req_q  <= req_d;
            pend_q <= pend_d;
            gnt_q  <= gnt_d;
            gid_q  <= gid_d;
            ptr_q  <= ptr_d;
            ovf_q  <= ovf_d;
            for (int i = 0; i < STAGES; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign gnt      = gnt_q;
    assign pend     = pend_q;
    assign ovf      = ovf_q;
    assign resp_vld = pipe_q[STAGES-1].vld;
    assign resp_id  = IDW'(pipe_q[STAGES-1].id);

`ifdef RISE_SCHED_SVA_EN
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_id_idle:     assert property (@(posedge clk) disable iff (rst) !resp_vld |-> resp_id == '0);
    a_flush_pend:  assert property (@(posedge clk) disable iff (rst) flush |=> pend == '0);
    for (genvar g = 0; g < NREQ; g++) begin : g_lat
        a_gnt_resp: assert property (@(posedge clk) disable iff (rst)
            gnt[g] |-> ##(LATENCY-1) (resp_vld && resp_id == IDW'(g)));
    end
`else
`endif

endmodule

// File: tb/tb_rise_resp_sched.sv
// Randomised + directed bench for rise_resp_sched with a timestamped response scoreboard.
module tb_rise_resp_sched;
    import rise_sched_pkg::*;

    localparam int NREQ    = 4;
    localparam int LATENCY = 10;
    localparam int IDW     = 2;

    logic            clk = 1'b0;
    logic            rst, en, flush, ovf_clr;
    logic [NREQ-1:0] req, gnt, pend;
    logic            resp_vld, ovf;
    logic [IDW-1:0]  resp_id;

    always #5 clk = ~clk;

    rise_resp_sched #(.NREQ(NREQ), .LATENCY(LATENCY)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .flush    (flush),
        .req      (req),
        .gnt      (gnt),
        .pend     (pend),
        .resp_vld (resp_vld),
        .resp_id  (resp_id),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    typedef struct { int due; int id; } exp_t;
    exp_t exp_q[$];

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: what the block should be presenting after each edge.
    bit [NREQ-1:0] m_prev, m_pend, m_gnt, m_rose, m_cand;
    int            m_ptr, m_win;
    bit            m_ovf, m_hit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_prev = '0; m_pend = '0; m_gnt = '0; m_ptr = 0; m_ovf = 1'b0;
            exp_q.delete();
        end else begin
            m_rose = req & ~m_prev;
            m_cand = m_pend | m_rose;
            m_hit  = |(m_rose & m_pend);
            m_win  = -1;
            if (en && !flush) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_win < 0 && m_cand[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
                end
            end
            m_gnt = '0;
            if (m_win >= 0) begin
                m_gnt[m_win] = 1'b1;
                m_ptr = (m_win + 1) % NREQ;
                exp_q.push_back('{due: cyc + LATENCY - 1, id: m_win});
            end
            m_pend = flush ? '0 : (m_cand & ~m_gnt);
            if (m_hit) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            m_prev = req;
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        check("gnt",  32'(gnt),  32'(m_gnt));
        check("pend", 32'(pend), 32'(m_pend));
        check("ovf",  32'(ovf),  32'(m_ovf));
        if (resp_vld) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(resp_vld), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_edge", 32'(cyc), 32'(e.due));
                check("resp_id",   32'(resp_id), 32'(e.id));
            end
        end else begin
            check("resp_id_idle", 32'(resp_id), 32'd0);
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                check("resp_missing", 32'(resp_vld), 32'd1);
            end
        end
    end

    task automatic drive(input logic [NREQ-1:0] r, input logic e, input logic f,
                         input logic oc, input int n);
        repeat (n) begin
            @(negedge clk);
            req = r; en = e; flush = f; ovf_clr = oc;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; flush = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; en = 1'b1; flush = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // T1: single uncontended rise
        drive(4'b0001, 1, 0, 0, 15);
        drive(4'b0000, 1, 0, 0, 2);

        // T2: simultaneous rises from ptr 0
        pulse_reset();
        drive(4'b0101, 1, 0, 0, 14);
        drive(4'b0000, 1, 0, 0, 2);

        // T3: double rise while disabled -> overflow, single response
        drive(4'b0010, 0, 0, 0, 1);
        drive(4'b0000, 0, 0, 0, 1);
        drive(4'b0010, 0, 0, 0, 1);
        drive(4'b0000, 0, 0, 0, 1);
        drive(4'b0000, 1, 0, 0, 14);
        drive(4'b0000, 1, 0, 1, 1);

        // T4: request held pending while disabled
        drive(4'b1000, 0, 0, 0, 5);
        drive(4'b1000, 1, 0, 0, 14);
        drive(4'b0000, 1, 0, 0, 2);

        // T5: reset with responses in flight
        drive(4'b0001, 1, 0, 0, 1);
        drive(4'b0011, 1, 0, 0, 1);
        drive(4'b0111, 1, 0, 0, 3);
        pulse_reset();
        drive(4'b0000, 1, 0, 0, 14);

        // T6: flush coinciding with a rise
        drive(4'b0000, 1, 0, 0, 1);
        drive(4'b0100, 1, 1, 0, 1);
        drive(4'b0100, 1, 0, 0, 14);
        drive(4'b0000, 1, 0, 0, 2);

        // Random contention, overflow, flush, clear and occasional reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) begin
                pulse_reset();
            end else begin
                drive(4'($urandom), ($urandom_range(7) != 0), ($urandom_range(15) == 0),
                      ($urandom_range(15) == 0), 1);
            end
        end

        drive(4'b0000, 1, 0, 0, LATENCY + NREQ + 6);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
